gcm_stream_sequencer: RTL and testbench
=======================================

# gcm_stream_sequencer

Upstream front end for the AES-GCM core. Accepts a 32-bit word stream of AAD followed by plaintext/ciphertext with valid/ready handshaking. Packs the words into 128-bit blocks, zero-pads partial blocks, and accumulates bit lengths. Drives the core's control vector and block inputs through hash-key setup, AAD, text and final length-block phases, using the core's ready flag as the per-block acknowledge.

## Interface
- No parameters. Block width 128, word width 32, length counters 64 are fixed constants.
- iClk  in  1  clock
- iRstn  in  1  reset, synchronous, active-low
- iStart  in  1  session start pulse, sampled in IDLE only
- iEncdec  in  1  1 = encrypt, 0 = decrypt; latched on iStart
- iHasAad / iHasText  in  1 each  segment present flags; latched on iStart
- iData  in  [0:31]  stream word, first byte in bits [0:7]
- iData_kind  in  1  0 = AAD, 1 = text
- iData_last  in  1  last word of the current segment
- iData_bytes  in  3  valid bytes in a last word, 1..4; ignored when not last
- iData_valid  in  1  word valid
- oData_ready  out  1  word accepted when valid & ready
- oCtrl  out  [0:3]  core control: [0] init, [1] next, [2] encdec, [3] tag phase
- iCoreReady  in  1  core block-complete flag
- oAad  out  [0:127]  AAD or length block to core
- oAad_valid  out  1  AAD/length block valid
- oBlock  out  [0:127]  text block to core
- oBlock_valid / oBlock_last  out  1 each  text block valid / final text block
- oBusy  out  1  session active
- oDone  out  1  one-cycle pulse at session end
- oErr  out  1  sticky kind-order violation, cleared by iStart

## Operation
- States: IDLE, HKEY, FILL, ISSUE, ACK_LO, ACK_HI, LEN, DONE.
- IDLE: oCtrl = 0. iStart latches the flags, clears the length counters and buffer, and moves to HKEY.
- HKEY: raise oCtrl[0]. oCtrl[0] stays high until DONE. Go to ISSUE with no block valid. The acknowledge completes the hash key.
- FILL:
  - The word index (0..3) selects buffer slot bits [32i:32i+31].
  - In a last word, bytes at or beyond iData_bytes are written as zero.
  - Length counter for the word's kind += 8*bytes (4 for non-last words).
  - The block closes on index 3 or on iData_last. Unfilled slots stay zero.
- AAD precedes text. A word whose kind differs from the current segment sets oErr and is accepted and discarded.
- ISSUE: hold the block on oAad/oAad_valid (AAD) or oBlock/oBlock_valid (text). Drive oCtrl[1] = 1 for exactly one cycle. oBlock_last = 1 on the final text block.
- ACK_LO: wait for iCoreReady = 0. ACK_HI: wait for iCoreReady = 1. Block valids stay held through ACK_HI and drop on exit.
- After ACK_HI, go to the next FILL, or to LEN when the text segment (or, with no text, the AAD segment) has ended.
- Empty segments (flag = 0) are skipped. With both flags 0, HKEY leads directly to LEN.
- LEN: oAad = {lenA[63:0], lenC[63:0]} bits, oAad_valid = 1, oCtrl[3] = 1. Then ISSUE, ACK_LO, ACK_HI. DONE then pulses oDone and returns to IDLE.
- Length counters wrap modulo 2^64 with no flag.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-session: everything returns to IDLE within one cycle. oCtrl goes to 0 and the core is abandoned.
- oData_ready is 1 only in FILL. A word accepted in cycle t is in the buffer at t+1. The block close moves to ISSUE at t+1.
- oCtrl[1] is high exactly one cycle per block. Minimum two idle cycles separate consecutive next pulses.
- oCtrl[2] is stable from HKEY to DONE.
- iStart while oBusy is ignored. iCoreReady already high at ACK_LO entry is not taken as the acknowledge.
- oBusy = 1 from the cycle after iStart through the DONE cycle.

## Structure
- Shared package gcm_pkg: state enum, BLK_W = 128, WORD_W = 32, LEN_W = 64, oCtrl bit indices.
- One sub-module, gcm_block_packer: word-to-block buffer, byte masking, index counter and length counters. The FSM stays in the top.

## Test plan
- iHasAad = 1, iHasText = 0, AAD of 5 words, last word bytes = 4 -> two AAD blocks, the second being word4 followed by 96'h0; LEN block = {64'd160, 64'd0}; oDone pulses once.
- Encrypt, no AAD, 16 bytes of text -> one oBlock with oBlock_last = 1; LEN = {64'd0, 64'd128}; oCtrl[2] = 1 throughout.
- Text last word 32'hAABBCCDD with bytes = 1 -> slot reads 32'hAA000000; lenC grows by 8.
- Core holds iCoreReady high for 3 cycles after next -> sequencer waits for the low then high transition, with no early advance; valids held.
- Kind = 0 word after text starts -> oErr = 1, word dropped, session completes with the correct lenC.
- Reset asserted in ACK_LO -> next cycle all outputs 0, state IDLE; a new iStart runs a clean session.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared types and constants for the AES-GCM stream front end.
// Control-vector bit indices, sequencer states, phases and the length-block layout.
package gcm_pkg;
  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 64;

  localparam int CTRL_INIT   = 0;
  localparam int CTRL_NEXT   = 1;
  localparam int CTRL_ENCDEC = 2;
  localparam int CTRL_TAG    = 3;

  typedef enum logic [2:0] {
    IDLE, HKEY, FILL, ISSUE, ACK_LO, ACK_HI, LEN, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_HKEY, PH_AAD, PH_TEXT, PH_LEN
  } phase_t;

  // Final GHASH block: AAD bit length in the upper half, text bit length in the lower half.
  typedef struct packed {
    logic [LEN_W-1:0] aad;
    logic [LEN_W-1:0] text;
  } len_blk_t;
endpackage

// File: rtl/gcm_block_packer.sv
// Packs 32-bit words into a 128-bit block with byte masking on last words; tracks bit lengths.
// Write lands in the buffer the cycle after iWr; oClose is combinational with the closing write.
module gcm_block_packer
  import gcm_pkg::*;
(
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iClr_all,
  input  logic              iClr_blk,
  input  logic              iWr,
  input  logic [0:WORD_W-1] iWord,
  input  logic              iKind,
  input  logic              iLast,
  input  logic [2:0]        iBytes,
  output logic [0:BLK_W-1]  oBlk,
  output logic              oClose,
  output len_blk_t          oLens
);
  logic [1:0]        idx;
  logic [2:0]        nb;
  logic [0:WORD_W-1] word_m;
  logic [LEN_W-1:0]  len_inc;

  assign nb      = iLast ? iBytes : 3'd4;
  assign len_inc = LEN_W'({nb, 3'b000});
  assign oClose  = iWr && ((idx == 2'd3) || iLast);

  always_comb begin
    word_m = '0;
    for (int b = 0; b < WORD_W / 8; b++)
      if (3'(b) < nb) word_m[8*b +: 8] = iWord[8*b +: 8];
  end

  always_ff @(posedge iClk) begin
    if (!iRstn || iClr_all) begin
      oBlk  <= '0;
      idx   <= '0;
      oLens <= '0;
    end else begin
      if (iClr_blk) begin
        oBlk <= '0;
        idx  <= '0;
      end else if (iWr) begin
        oBlk[WORD_W*idx +: WORD_W] <= word_m;
        idx <= idx + 2'd1;
      end
      if (iWr) begin
        if (iKind) oLens.text <= oLens.text + len_inc;
        else       oLens.aad  <= oLens.aad + len_inc;
      end
    end
  end
endmodule

// File: rtl/gcm_stream_sequencer.sv
// Front end for the AES-GCM core: hash-key setup, AAD blocks, text blocks, then the length block.
// Words are taken only in FILL; each block is held until the core's ready goes low then high.
module gcm_stream_sequencer
  import gcm_pkg::*;
(
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iStart,
  input  logic              iEncdec,
  input  logic              iHasAad,
  input  logic              iHasText,
  input  logic [0:WORD_W-1] iData,
  input  logic              iData_kind,
  input  logic              iData_last,
  input  logic [2:0]        iData_bytes,
  input  logic              iData_valid,
  output logic              oData_ready,
  output logic [0:3]        oCtrl,
  input  logic              iCoreReady,
  output logic [0:BLK_W-1]  oAad,
  output logic              oAad_valid,
  output logic [0:BLK_W-1]  oBlock,
  output logic              oBlock_valid,
  output logic              oBlock_last,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);
  state_t           state, state_nxt;
  phase_t           phase, phase_nxt;
  logic             encdec_q, has_aad_q, has_text_q, err_q, seg_last_q;
  logic             acc, kind_ok, pk_wr, pk_close, pk_clr_all, pk_clr_blk, in_blk;
  logic [0:BLK_W-1] blk, len_bits;
  len_blk_t         lens;

  gcm_block_packer u_packer (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .iClr_all (pk_clr_all),
    .iClr_blk (pk_clr_blk),
    .iWr      (pk_wr),
    .iWord    (iData),
    .iKind    (iData_kind),
    .iLast    (iData_last),
    .iBytes   (iData_bytes),
    .oBlk     (blk),
    .oClose   (pk_close),
    .oLens    (lens)
  );

  // Out-of-order words are consumed so the stream keeps moving, but never reach the buffer.
  assign acc        = (state == FILL) && iData_valid;
  assign kind_ok    = (iData_kind == (phase == PH_TEXT));
  assign pk_wr      = acc && kind_ok;
  assign pk_clr_all = (state == IDLE) && iStart;

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state      <= IDLE;
      phase      <= PH_HKEY;
      encdec_q   <= 1'b0;
      has_aad_q  <= 1'b0;
      has_text_q <= 1'b0;
      err_q      <= 1'b0;
      seg_last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (pk_clr_all) begin
        encdec_q   <= iEncdec;
        has_aad_q  <= iHasAad;
        has_text_q <= iHasText;
        err_q      <= 1'b0;
        seg_last_q <= 1'b0;
      end else if (acc && !kind_ok) begin
        err_q <= 1'b1;
      end
      if (pk_close) seg_last_q <= iData_last;
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    pk_clr_blk = 1'b0;
    case (state)
      IDLE:   if (iStart) begin
                state_nxt = HKEY;
                phase_nxt = PH_HKEY;
              end
      HKEY:   state_nxt = ISSUE;
      FILL:   if (pk_close) state_nxt = ISSUE;
      ISSUE:  state_nxt = ACK_LO;
      ACK_LO: if (!iCoreReady) state_nxt = ACK_HI;
      ACK_HI: if (iCoreReady) begin
                pk_clr_blk = 1'b1;
                state_nxt  = FILL;
                case (phase)
                  PH_HKEY: if (has_aad_q)       phase_nxt = PH_AAD;
                           else if (has_text_q) phase_nxt = PH_TEXT;
                           else                 phase_nxt = PH_LEN;
                  PH_AAD:  if (seg_last_q) phase_nxt = has_text_q ? PH_TEXT : PH_LEN;
                  PH_TEXT: if (seg_last_q) phase_nxt = PH_LEN;
                  default: state_nxt = DONE;
                endcase
                if (phase != PH_LEN && phase_nxt == PH_LEN) state_nxt = LEN;
              end
      LEN:    state_nxt = ISSUE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_blk       = (state == ISSUE) || (state == ACK_LO) || (state == ACK_HI);
  assign len_bits     = lens;
  assign oAad_valid   = (in_blk && (phase == PH_AAD || phase == PH_LEN)) || (state == LEN);
  assign oAad         = !oAad_valid ? '0 : ((phase == PH_LEN) ? len_bits : blk);
  assign oBlock_valid = in_blk && (phase == PH_TEXT);
  assign oBlock       = oBlock_valid ? blk : '0;
  assign oBlock_last  = oBlock_valid && seg_last_q;
  assign oData_ready  = (state == FILL);
  assign oBusy        = (state != IDLE);
  assign oDone        = (state == DONE);
  assign oErr         = err_q;

  always_comb begin
    oCtrl              = '0;
    oCtrl[CTRL_INIT]   = (state != IDLE) && (state != DONE);
    oCtrl[CTRL_NEXT]   = (state == ISSUE);
    oCtrl[CTRL_ENCDEC] = (state != IDLE) && encdec_q;
    oCtrl[CTRL_TAG]    = (phase == PH_LEN) && (in_blk || state == LEN);
  end
endmodule

// File: tb/tb_gcm_stream_sequencer.sv
// Directed bench for gcm_stream_sequencer with hand-computed blocks and length words.
module tb_gcm_stream_sequencer;
  logic         iClk, iRstn, iStart, iEncdec, iHasAad, iHasText;
  logic [0:31]  iData;
  logic         iData_kind, iData_last, iData_valid, oData_ready;
  logic [2:0]   iData_bytes;
  logic [0:3]   oCtrl;
  logic         iCoreReady;
  logic [0:127] oAad, oBlock;
  logic         oAad_valid, oBlock_valid, oBlock_last, oBusy, oDone, oErr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int enc_bad = 0;
  logic enc_mon = 1'b0;

  gcm_stream_sequencer dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iEncdec(iEncdec),
    .iHasAad(iHasAad), .iHasText(iHasText), .iData(iData), .iData_kind(iData_kind),
    .iData_last(iData_last), .iData_bytes(iData_bytes), .iData_valid(iData_valid),
    .oData_ready(oData_ready), .oCtrl(oCtrl), .iCoreReady(iCoreReady),
    .oAad(oAad), .oAad_valid(oAad_valid), .oBlock(oBlock), .oBlock_valid(oBlock_valid),
    .oBlock_last(oBlock_last), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oDone) done_cnt <= done_cnt + 1;
    if (enc_mon && oBusy && !oCtrl[2]) enc_bad <= enc_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic enc, input logic aad, input logic txt);
    iEncdec = enc; iHasAad = aad; iHasText = txt; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    chk("start_busy", oBusy, 1);
    chk("start_init", oCtrl[0], 1);
    chk("start_enc", oCtrl[2], enc);
  endtask

  task automatic send(input logic kind, input logic [31:0] d, input logic last, input logic [2:0] nb);
    logic ok;
    ok = 1'b0;
    iData = d; iData_kind = kind; iData_last = last; iData_bytes = nb; iData_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (oData_ready) ok = 1'b1;
      @(negedge iClk);
    end
    iData_valid = 1'b0; iData_last = 1'b0;
    if (!ok) chk("send_ready", ok, 1);
  endtask

  task automatic core_ack(input int hold, input logic av, input logic bv);
    @(negedge iClk);
    for (int i = 0; i < hold; i++) begin
      chk("hold_wait", {oCtrl[1], oAad_valid, oBlock_valid, oData_ready}, {1'b0, av, bv, 1'b0});
      @(negedge iClk);
    end
    iCoreReady = 1'b0;
    @(negedge iClk);
    chk("ackhi_valid", {oAad_valid, oBlock_valid}, {av, bv});
    iCoreReady = 1'b1;
    @(negedge iClk);
    chk("exit_blk_drop", oBlock_valid, 0);
  endtask

  task automatic issue(input string tag, input logic av, input logic [127:0] ad,
                       input logic bv, input logic [127:0] bd, input logic bl,
                       input logic tg, input int hold);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (oCtrl[1]) ok = 1'b1;
      else @(negedge iClk);
    end
    chk({tag, "_next"}, ok, 1);
    chk({tag, "_aad_v"}, oAad_valid, av);
    chk({tag, "_blk_v"}, oBlock_valid, bv);
    chk({tag, "_tag"}, oCtrl[3], tg);
    if (av) chk({tag, "_aad"}, oAad, ad);
    if (bv) chk({tag, "_blk"}, oBlock, bd);
    if (bv) chk({tag, "_last"}, oBlock_last, bl);
    core_ack(hold, av, bv);
  endtask

  task automatic finish_session(input string tag, input int d0);
    chk({tag, "_done"}, oDone, 1);
    chk({tag, "_done_init"}, oCtrl[0], 0);
    @(negedge iClk);
    chk({tag, "_idle"}, {oBusy, oDone, oCtrl[1]}, 3'b000);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    iRstn = 1'b0; iStart = 1'b0; iEncdec = 1'b0; iHasAad = 1'b0; iHasText = 1'b0;
    iData = '0; iData_kind = 1'b0; iData_last = 1'b0; iData_bytes = 3'd0;
    iData_valid = 1'b0; iCoreReady = 1'b1;
    repeat (3) @(negedge iClk);
    chk("rst_ctrl", oCtrl, 0);
    chk("rst_flags", {oData_ready, oAad_valid, oBlock_valid, oBlock_last, oBusy, oDone, oErr}, 0);
    chk("rst_aad", oAad, 0);
    chk("rst_blk", oBlock, 0);
    iRstn = 1'b1;
    @(negedge iClk);

    // AAD only, five words: one full block, then word4 padded with zeros
    d0 = done_cnt;
    start(0, 1, 0);
    issue("t1_hkey", 0, '0, 0, '0, 0, 0, 0);
    send(0, 32'h00010203, 0, 3'd4);
    send(0, 32'h04050607, 0, 3'd4);
    send(0, 32'h08090A0B, 0, 3'd4);
    send(0, 32'h0C0D0E0F, 0, 3'd4);
    issue("t1_b0", 1, 128'h000102030405060708090A0B0C0D0E0F, 0, '0, 0, 0, 0);
    send(0, 32'h10111213, 1, 3'd4);
    issue("t1_b1", 1, {32'h10111213, 96'h0}, 0, '0, 0, 0, 0);
    issue("t1_len", 1, {64'd160, 64'd0}, 0, '0, 0, 1, 0);
    finish_session("t1", d0);

    // Encrypt, text only, 16 bytes
    d0 = done_cnt;
    enc_bad = 0;
    enc_mon = 1'b1;
    start(1, 0, 1);
    issue("t2_hkey", 0, '0, 0, '0, 0, 0, 0);
    send(1, 32'h00112233, 0, 3'd4);
    send(1, 32'h44556677, 0, 3'd4);
    send(1, 32'h8899AABB, 0, 3'd4);
    send(1, 32'hCCDDEEFF, 1, 3'd4);
    issue("t2_b0", 0, '0, 1, 128'h00112233445566778899AABBCCDDEEFF, 1, 0, 0);
    issue("t2_len", 1, {64'd0, 64'd128}, 0, '0, 0, 1, 0);
    finish_session("t2", d0);
    enc_mon = 1'b0;
    chk("t2_encdec_stable", enc_bad, 0);

    // Single text byte in the last word
    d0 = done_cnt;
    start(0, 0, 1);
    issue("t3_hkey", 0, '0, 0, '0, 0, 0, 0);
    send(1, 32'hAABBCCDD, 1, 3'd1);
    issue("t3_b0", 0, '0, 1, {32'hAA000000, 96'h0}, 1, 0, 0);
    issue("t3_len", 1, {64'd0, 64'd8}, 0, '0, 0, 1, 0);
    finish_session("t3", d0);

    // Core keeps ready high for 3 cycles after next: no early advance
    d0 = done_cnt;
    start(0, 1, 0);
    issue("t4_hkey", 0, '0, 0, '0, 0, 0, 0);
    send(0, 32'hDEADBEEF, 1, 3'd2);
    issue("t4_b0", 1, {32'hDEAD0000, 96'h0}, 0, '0, 0, 0, 3);
    chk("t4_len_tag", oCtrl[3], 1);
    chk("t4_len_state", oAad, {64'd16, 64'd0});
    issue("t4_len", 1, {64'd16, 64'd0}, 0, '0, 0, 1, 0);
    finish_session("t4", d0);

    // AAD word after text has started: flagged and dropped
    d0 = done_cnt;
    start(0, 1, 1);
    issue("t5_hkey", 0, '0, 0, '0, 0, 0, 0);
    send(0, 32'h11223344, 1, 3'd4);
    issue("t5_a0", 1, {32'h11223344, 96'h0}, 0, '0, 0, 0, 0);
    chk("t5_err_clear", oErr, 0);
    send(1, 32'hA1A2A3A4, 0, 3'd4);
    send(0, 32'hFFFFFFFF, 0, 3'd4);
    chk("t5_err_set", oErr, 1);
    send(1, 32'hB1B2B3B4, 1, 3'd3);
    issue("t5_b0", 0, '0, 1, {32'hA1A2A3A4, 32'hB1B2B300, 64'h0}, 1, 0, 0);
    issue("t5_len", 1, {64'd32, 64'd56}, 0, '0, 0, 1, 0);
    finish_session("t5", d0);
    chk("t5_err_sticky", oErr, 1);

    // No segments: hash key, then straight to the length block
    d0 = done_cnt;
    start(0, 0, 0);
    chk("t6_err_cleared", oErr, 0);
    issue("t6_hkey", 0, '0, 0, '0, 0, 0, 0);
    issue("t6_len", 1, {64'd0, 64'd0}, 0, '0, 0, 1, 0);
    finish_session("t6", d0);

    // Reset while waiting in ACK_LO, then a clean session
    start(1, 1, 0);
    for (int i = 0; i < 8 && !oCtrl[1]; i++) @(negedge iClk);
    @(negedge iClk);
    iRstn = 1'b0;
    @(negedge iClk);
    chk("t7_rst_ctrl", oCtrl, 0);
    chk("t7_rst_flags", {oData_ready, oAad_valid, oBlock_valid, oBlock_last, oBusy, oDone, oErr}, 0);
    chk("t7_rst_aad", oAad, 0);
    iRstn = 1'b1;
    @(negedge iClk);
    d0 = done_cnt;
    start(0, 1, 0);
    issue("t7_hkey", 0, '0, 0, '0, 0, 0, 0);
    send(0, 32'h01020304, 1, 3'd4);
    issue("t7_a0", 1, {32'h01020304, 96'h0}, 0, '0, 0, 0, 0);
    issue("t7_len", 1, {64'd32, 64'd0}, 0, '0, 0, 1, 0);
    finish_session("t7", d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
